// File: rtl/vga_line_fetch.sv
// Line prefetch buffer: bursts one 32-byte pixel row from shared screen RAM into the
// back bank of a double-buffered line store while the renderer reads the front bank.
module vga_line_fetch #(
    parameter logic [10:0] BASE_ADDR = 11'h200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [4:0]  fetch_row,
    input  logic        line_swap,
    output logic        mem_req,
    input  logic        mem_grant,
    output logic [10:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic [4:0]  pix_x,
    output logic [7:0]  pix_data,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic       fill_bank_q, fill_bank_d;
    logic       front_bank_q, front_bank_d;
    logic       overrun_q, overrun_d;
    logic       cap_vld_q, cap_vld_d;
    logic [4:0] cap_col_q, cap_col_d;
    logic [7:0] pix_data_q, pix_data_d;
    logic       issue;
    logic       wr_en0, wr_en1;

    logic [7:0] bank0_q [32];
    logic [7:0] bank1_q [32];

    assign issue   = (state_q == S_FETCH) && mem_grant;
    assign mem_req = (state_q == S_FETCH);
    assign busy    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign overrun = overrun_q;
    assign pix_data = pix_data_q;
    assign mem_addr = BASE_ADDR + {1'b0, row_q, col_q};

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        fill_bank_d  = fill_bank_q;
        // A swap coincident with fetch_start lands first, so fill_bank uses the new front.
        front_bank_d = front_bank_q ^ line_swap;
        overrun_d    = overrun_q
                     | (line_swap && busy)
                     | (fetch_start && (state_q != S_IDLE));
        cap_vld_d    = issue;
        cap_col_d    = col_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    row_d       = fetch_row;
                    fill_bank_d = ~front_bank_d;
                    col_d       = 5'd0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    col_d = col_q + 5'd1;
                    if (col_q == 5'd31) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pix_data_d = front_bank_q ? bank1_q[pix_x] : bank0_q[pix_x];
        wr_en0     = cap_vld_q && !fill_bank_q;
        wr_en1     = cap_vld_q && fill_bank_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_q        <= 5'd0;
            col_q        <= 5'd0;
            fill_bank_q  <= 1'b0;
            front_bank_q <= 1'b0;
            overrun_q    <= 1'b0;
            cap_vld_q    <= 1'b0;
            cap_col_q    <= 5'd0;
            pix_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            fill_bank_q  <= fill_bank_d;
            front_bank_q <= front_bank_d;
            overrun_q    <= overrun_d;
            cap_vld_q    <= cap_vld_d;
            cap_col_q    <= cap_col_d;
            pix_data_q   <= pix_data_d;
        end
    end

    // Line store is not reset; non-blocking writes give read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (wr_en0) begin
            bank0_q[cap_col_q] <= mem_data;
        end
        if (wr_en1) begin
            bank1_q[cap_col_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch: two instances (default base and a wrapping base) share stimulus.
module tb_vga_line_fetch;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic [4:0]  fetch_row;
    logic        line_swap;
    logic        mem_grant;
    logic [4:0]  pix_x;
    logic        mem_req_a, mem_req_b;
    logic [10:0] mem_addr_a, mem_addr_b;
    logic [7:0]  mem_data_a, mem_data_b;
    logic [7:0]  pix_data_a, pix_data_b;
    logic        busy_a, busy_b, done_a, done_b, overrun_a, overrun_b;

    int checks = 0;
    int failures = 0;

    logic [10:0] addr_q_a [$];
    logic [10:0] addr_q_b [$];
    logic [7:0]  pix_q_a [$];
    logic [7:0]  pix_q_b [$];

    vga_line_fetch #(.BASE_ADDR(11'h200)) dut_a (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .fetch_row(fetch_row),
        .line_swap(line_swap), .mem_req(mem_req_a), .mem_grant(mem_grant),
        .mem_addr(mem_addr_a), .mem_data(mem_data_a), .pix_x(pix_x),
        .pix_data(pix_data_a), .busy(busy_a), .done(done_a), .overrun(overrun_a)
    );

    vga_line_fetch #(.BASE_ADDR(11'h7F0)) dut_b (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .fetch_row(fetch_row),
        .line_swap(line_swap), .mem_req(mem_req_b), .mem_grant(mem_grant),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b), .pix_x(pix_x),
        .pix_data(pix_data_b), .busy(busy_b), .done(done_b), .overrun(overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Screen RAM model: byte = addr[7:0], one-cycle read latency, junk when nothing issues.
    always @(posedge clk) begin
        if (mem_req_a && mem_grant) mem_data_a <= mem_addr_a[7:0];
        else                        mem_data_a <= 8'($urandom);
        if (mem_req_b && mem_grant) mem_data_b <= mem_addr_b[7:0];
        else                        mem_data_b <= 8'($urandom);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_swap();
        line_swap = 1'b1;
        @(posedge clk);
        #1;
        line_swap = 1'b0;
    endtask

    task automatic check_front(input logic [4:0] row, input int lo, input int hi);
        logic [10:0] t;
        logic [7:0]  ea, eb;
        for (int k = lo; k <= hi + 1; k++) begin
            if (k > lo) begin
                ea = pix_q_a.pop_front();
                eb = pix_q_b.pop_front();
                checks++;
                if (pix_data_a !== ea || pix_data_b !== eb) begin
                    failures++;
                    $display("FAIL pix_row%0d_col%0d got=%h/%h exp=%h/%h",
                             row, k - 1, pix_data_a, pix_data_b, ea, eb);
                end
            end
            if (k <= hi) begin
                pix_x = 5'(k);
                t = 11'h200 + {1'b0, row, 5'(k)};
                pix_q_a.push_back(t[7:0]);
                t = 11'h7F0 + {1'b0, row, 5'(k)};
                pix_q_b.push_back(t[7:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_fetch(input logic [4:0] row, input int st_col0, input int st_n0,
                             input int st_col1, input int st_n1, input int swap_cyc,
                             input bit poke_drain, input int rst_cyc, input int exp_done);
        int rem0, rem1, ncol, dcount;
        bit fin;
        logic [10:0] ea, eb;
        rem0 = st_n0;
        rem1 = st_n1;
        addr_q_a.delete();
        addr_q_b.delete();
        for (int i = 0; i < 32; i++) begin
            addr_q_a.push_back(11'h200 + {1'b0, row, 5'(i)});
            addr_q_b.push_back(11'h7F0 + {1'b0, row, 5'(i)});
        end
        fetch_row = row;
        fetch_start = 1'b1;
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        fin = 1'b0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            line_swap = 1'b0;
            fetch_start = 1'b0;
            mem_grant = 1'b1;
            ncol = 32 - addr_q_a.size();
            if (mem_req_a) begin
                if (ncol == st_col0 && rem0 > 0) begin mem_grant = 1'b0; rem0--; end
                else if (ncol == st_col1 && rem1 > 0) begin mem_grant = 1'b0; rem1--; end
            end
            if (c == swap_cyc) line_swap = 1'b1;
            if (poke_drain && busy_a && !mem_req_a) begin
                fetch_start = 1'b1;
                fetch_row = row + 5'd1;
            end
            if (c == rst_cyc) reset = 1'b1;
            if (rst_cyc < 0) begin
                checks++;
                if (busy_a !== (c < exp_done) || busy_b !== (c < exp_done)) begin
                    failures++;
                    $display("FAIL busy_cycle%0d got=%b/%b exp=%b", c, busy_a, busy_b, c < exp_done);
                end
            end
            if (mem_req_a && mem_grant) begin
                checks++;
                if (addr_q_a.size() == 0) begin
                    failures++;
                    $display("FAIL extra_issue cycle=%0d addr=%h exp=none", c, mem_addr_a);
                end else begin
                    ea = addr_q_a.pop_front();
                    eb = addr_q_b.pop_front();
                    if (mem_addr_a !== ea || mem_addr_b !== eb) begin
                        failures++;
                        $display("FAIL mem_addr cycle=%0d got=%h/%h exp=%h/%h",
                                 c, mem_addr_a, mem_addr_b, ea, eb);
                    end
                end
            end
            if (done_a || done_b) begin
                checks++;
                if (c != exp_done || rst_cyc > 0 || done_a !== done_b) begin
                    failures++;
                    $display("FAIL done_cycle got=%0d exp=%0d", c, exp_done);
                end
                fin = 1'b1;
            end
            if (swap_cyc > 0 && c == swap_cyc + 1) begin
                checks++;
                if (overrun_a !== 1'b1) begin
                    failures++;
                    $display("FAIL overrun_after_swap got=%b exp=1", overrun_a);
                end
            end
            @(posedge clk);
            #1;
            if (c == rst_cyc) begin
                reset = 1'b0;
                checks++;
                if (mem_req_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || mem_req_b !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid req/busy/done got=%b%b%b exp=000", mem_req_a, busy_a, done_a);
                end
                fin = 1'b1;
            end
        end
        line_swap = 1'b0;
        fetch_start = 1'b0;
        mem_grant = 1'b1;
        if (rst_cyc > 0) begin
            dcount = 0;
            for (int i = 0; i < 40; i++) begin
                if (done_a || done_b || mem_req_a) dcount++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (dcount != 0) begin
                failures++;
                $display("FAIL after_reset_activity got=%0d exp=0", dcount);
            end
        end else begin
            checks++;
            if (!fin || addr_q_a.size() != 0) begin
                failures++;
                $display("FAIL fetch_complete done=%b left=%0d exp=1/0", fin, addr_q_a.size());
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || overrun_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b%b%b%b exp=0000", mem_req_a, busy_a, done_a, overrun_a);
        end
        checks++;
        if (pix_data_a !== 8'h00 || pix_data_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_pix got=%h/%h exp=00", pix_data_a, pix_data_b);
        end
        checks++;
        if (mem_addr_a !== 11'h200 || mem_addr_b !== 11'h7F0) begin
            failures++;
            $display("FAIL reset_addr got=%h/%h exp=200/7f0", mem_addr_a, mem_addr_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_fetch(5'd3, -1, 0, -1, 0, -1, 1'b0, -1, 34);
        do_swap();
        check_front(5'd3, 0, 31);
    endtask

    task automatic test_grant_stall();
        run_fetch(5'd5, 10, 3, 31, 1, -1, 1'b0, -1, 38);
        do_swap();
        check_front(5'd5, 0, 31);
    endtask

    task automatic test_double_buffer();
        run_fetch(5'd0, -1, 0, -1, 0, -1, 1'b0, -1, 34);
        do_swap();
        check_front(5'd0, 0, 31);
        run_fetch(5'd31, -1, 0, -1, 0, -1, 1'b0, -1, 34);
        check_front(5'd0, 0, 31);
        do_swap();
        check_front(5'd31, 0, 31);
    endtask

    task automatic test_errors();
        // The mid-fetch swap brings the still-filling bank to the front.
        run_fetch(5'd7, -1, 0, -1, 0, 10, 1'b0, -1, 34);
        check_front(5'd7, 0, 31);
        apply_reset();
        checks++;
        if (overrun_a !== 1'b0) begin
            failures++;
            $display("FAIL overrun_cleared got=%b exp=0", overrun_a);
        end
        run_fetch(5'd9, -1, 0, -1, 0, -1, 1'b1, -1, 34);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (overrun_a !== 1'b1 || overrun_b !== 1'b1 || mem_req_a !== 1'b0) begin
            failures++;
            $display("FAIL drain_poke overrun/req got=%b/%b exp=1/0", overrun_a, mem_req_a);
        end
        do_swap();
        check_front(5'd9, 0, 31);
    endtask

    task automatic test_reset_mid();
        // front=1 here, so the aborted fetch partially overwrites bank 0 (holding row 31).
        run_fetch(5'd4, -1, 0, -1, 0, -1, 1'b0, 15, 34);
        check_front(5'd4, 0, 12);
        check_front(5'd31, 16, 31);
        run_fetch(5'd6, -1, 0, -1, 0, -1, 1'b0, -1, 34);
        do_swap();
        check_front(5'd6, 0, 31);
    endtask

    task automatic test_wrap();
        run_fetch(5'd31, 4, 2, -1, 0, -1, 1'b0, -1, 36);
        do_swap();
        check_front(5'd31, 0, 31);
    endtask

    initial begin
        reset = 1'b1;
        fetch_start = 1'b0;
        fetch_row = 5'd0;
        line_swap = 1'b0;
        mem_grant = 1'b1;
        pix_x = 5'd0;
        test_reset();
        test_basic();
        test_grant_stall();
        test_double_buffer();
        test_errors();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
